event_generator: RTL

Synthetic event source for the event-filter datapath. Emits paced 8-bit packed address-events (x, y, polarity, timestamp) on a valid/ready handshake, in the same field layout the filter consumes on its input port. Used as an on-chip stimulus driver for the filter and as the transmit end of the event interface. Counts events it had to drop when the consumer stalls.

---
 rtl/event_generator_if.sv | 17 +
 rtl/event_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/event_generator_if.sv
// event_generator_if
//   Valid/ready event stream carrying one packed address-event per beat.
//   Signals:
//     ev_out   [7:0]  {x[1:0], y[1:0], p[1:0], t[1:0]}
//     ev_valid        ev_out holds an event
//     ev_ready        consumer accepts when ev_valid && ev_ready at a rising edge
//   Modports:
//     master  event source (drives ev_out/ev_valid, samples ev_ready)
//     slave   event sink   (samples ev_out/ev_valid, drives ev_ready)
interface event_generator_if;
    logic [7:0] ev_out;
    logic       ev_valid;
    logic       ev_ready;

    modport master (output ev_out, output ev_valid, input ev_ready);
    modport slave  (input ev_out, input ev_valid, output ev_ready);
endinterface

// File: rtl/event_generator.sv
// event_generator
//   Synthetic, paced source of packed address-events for the event-filter
//   datapath. Raster, random (LFSR) and hot-pixel patterns; events that cannot
//   be placed because the consumer stalls are counted in drop_cnt.
//
//   Build option: define EVENT_GENERATOR_LFSR_EN to include the random (LFSR)
//   pattern. Without it the LFSR is absent and mode 01 behaves as raster.
//
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     start, stop     run control pulses (stop wins over start)
//     mode   [1:0]    00 raster, 01 random, 10 hot-pixel, 11 raster
//     period [7:0]    cycles between ticks (0 treated as 1)
//     count  [7:0]    events to emit (0 = until stop)
//     hot_xy [3:0]    {x,y} for hot-pixel mode
//     ev              event stream (master side of event_generator_if)
//     busy            not idle
//     done            one-cycle pulse on normal completion
//     drop_cnt [7:0]  ticks lost to backpressure, saturating
module event_generator #(
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [7:0]        period,
    input  logic [7:0]        count,
    input  logic [3:0]        hot_xy,
    event_generator_if.master ev,
    output logic              busy,
    output logic              done,
    output logic [7:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state, state_next;

    logic [1:0] mode_q;
    logic [7:0] reload_q;
    logic [7:0] count_q;
    logic [3:0] hot_q;
    logic [7:0] timer;
    logic [7:0] ev_cnt;
    logic [1:0] t_cnt;
    logic [1:0] rx, ry;
    logic       rp;          // raster polarity: 0 -> ON (01), 1 -> OFF (10)
    logic       hp;          // hot-pixel polarity phase, same encoding
    logic [7:0] ev_out_q;
    logic       ev_valid_q;

    logic [7:0] p_reload;
    logic       launch, tick, slot_free, emit, last, finish;
    logic [7:0] ev_data;

    assign p_reload  = (period == 8'd0) ? 8'd0 : period - 8'd1;
    assign launch    = (state == IDLE) && start && !stop;
    assign tick      = (state == RUN) && !stop && (timer == 8'd0);
    // The output slot is free if empty or being emptied at this same edge.
    assign slot_free = !ev_valid_q || ev.ev_ready;
    assign emit      = tick && slot_free;
    assign last      = emit && (count_q != 8'd0) && (ev_cnt + 8'd1 == count_q);
    assign finish    = (state == DRAIN) && !stop && slot_free;

    assign ev.ev_out   = ev_out_q;
    assign ev.ev_valid = ev_valid_q;
    assign busy        = (state != IDLE);

`ifdef EVENT_GENERATOR_LFSR_EN
    // A zero seed would lock the LFSR at zero; fall back to 1.
    localparam logic [7:0] SEED = (LFSR_SEED != 8'h00) ? LFSR_SEED : 8'h01;

    logic [7:0] lfsr;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED;
        end else if (launch) begin
            lfsr <= SEED;
        end else if (tick) begin
            lfsr <= {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h71 : 8'h00);
        end
    end
`else
    // The seed only feeds the LFSR build.
    if (LFSR_SEED == 8'h00) begin : g_seed_unused
    end
`endif

    always_comb begin
        ev_data = {rx, ry, (rp ? 2'b10 : 2'b01), t_cnt};
        case (mode_q)
            2'b10:   ev_data = {hot_q, (hp ? 2'b10 : 2'b01), t_cnt};
`ifdef EVENT_GENERATOR_LFSR_EN
            2'b01:   ev_data = {lfsr[7:4], (lfsr[0] ? 2'b01 : 2'b10), t_cnt};
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = RUN;
            RUN: begin
                if (stop)      state_next = IDLE;
                else if (last) state_next = DRAIN;
            end
            DRAIN:   if (stop || finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            hot_q      <= '0;
            timer      <= '0;
            ev_cnt     <= '0;
            t_cnt      <= '0;
            rx         <= '0;
            ry         <= '0;
            rp         <= 1'b0;
            hp         <= 1'b0;
            ev_out_q   <= '0;
            ev_valid_q <= 1'b0;
            done       <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            done <= finish;
            if (launch) begin
                mode_q   <= mode;
                reload_q <= p_reload;
                count_q  <= count;
                hot_q    <= hot_xy;
                timer    <= p_reload;
                ev_cnt   <= '0;
                t_cnt    <= '0;
                rx       <= '0;
                ry       <= '0;
                rp       <= 1'b0;
                hp       <= 1'b0;
                drop_cnt <= '0;
            end else if (stop && state != IDLE) begin
                ev_valid_q <= 1'b0;
            end else if (state == RUN) begin
                if (tick) begin
                    // Pattern state advances on every tick, placed or dropped.
                    timer <= reload_q;
                    t_cnt <= t_cnt + 2'd1;
                    rx    <= rx + 2'd1;
                    hp    <= ~hp;
                    if (rx == 2'd3) begin
                        ry <= ry + 2'd1;
                        if (ry == 2'd3) rp <= ~rp;
                    end
                    if (emit) begin
                        ev_out_q   <= ev_data;
                        ev_valid_q <= 1'b1;
                        ev_cnt     <= ev_cnt + 8'd1;
                    end else if (drop_cnt != 8'hFF) begin
                        drop_cnt <= drop_cnt + 8'd1;
                    end
                end else begin
                    timer <= timer - 8'd1;
                    if (ev_valid_q && ev.ev_ready) ev_valid_q <= 1'b0;
                end
            end else if (state == DRAIN) begin
                if (ev_valid_q && ev.ev_ready) ev_valid_q <= 1'b0;
            end
        end
    end

endmodule
